// File: rtl/sort_job_scheduler.sv
// Round-robin front end that shares one sort core among several requesters.
// It also watches each core job with a timeout and returns the result tagged with the requester ID.
module sort_job_scheduler #(
  parameter int SIZE_DATA  = 8,
  parameter int NUM_VALS   = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_CYCLES = 256,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_REQ-1:0]                    i_req,
  input  logic [NUM_REQ*NUM_VALS*SIZE_DATA-1:0] i_req_data,
  output logic [NUM_REQ-1:0]                    o_req_ack,
  output logic                                  o_sort_start,
  output logic [NUM_VALS*SIZE_DATA-1:0]         o_sort_data,
  input  logic [NUM_VALS*SIZE_DATA-1:0]         i_sort_data,
  input  logic                                  i_sort_done,
  output logic                                  o_sort_clr,
  output logic                                  o_rsp_valid,
  input  logic                                  i_rsp_ready,
  output logic [ID_W-1:0]                       o_rsp_id,
  output logic [NUM_VALS*SIZE_DATA-1:0]         o_rsp_data,
  output logic                                  o_rsp_err,
  output logic                                  o_busy
);

  localparam int VEC_W = NUM_VALS * SIZE_DATA;
  localparam int CNT_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, CLEAR, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    job_id;
  logic [CNT_W-1:0]   cnt;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    scan_id;
  logic [ID_W-1:0]    next_ptr;
  logic [VEC_W-1:0]   win_vec;
  logic [NUM_REQ-1:0] ack_vec;
  int                 scan_idx;

  // Scan from rr_ptr upward and wrap. The loop runs backwards, so the closest candidate is assigned last and wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    scan_idx  = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_id = ID_W'(scan_idx);
      if (i_req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  always_comb begin
    win_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == ID_W'(k)) win_vec = i_req_data[k*VEC_W +: VEC_W];
    end
  end

  assign ack_vec  = NUM_REQ'(1) << win_id;
  assign next_ptr = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

  assign o_sort_clr = i_rst | (state == CLEAR);
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cnt          <= '0;
      job_id       <= '0;
      o_req_ack    <= '0;
      o_sort_start <= 1'b0;
      o_sort_data  <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_data   <= '0;
      o_rsp_err    <= 1'b0;
    end else begin
      o_req_ack    <= '0;
      o_sort_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            o_sort_data  <= win_vec;
            job_id       <= win_id;
            rr_ptr       <= next_ptr;
            o_req_ack    <= ack_vec;
            o_sort_start <= 1'b1;
            state        <= LAUNCH;
          end
        end
        // Any done seen here belongs to an earlier core run and is ignored.
        LAUNCH: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (i_sort_done) begin
            o_rsp_data  <= i_sort_data;
            o_rsp_err   <= 1'b0;
            o_rsp_id    <= job_id;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end else if (cnt == CNT_W'(MAX_CYCLES - 1)) begin
            cnt   <= '0;
            state <= CLEAR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Hold the core in clear for two cycles, then report a timeout.
        CLEAR: begin
          if (cnt == CNT_W'(1)) begin
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b1;
            o_rsp_id    <= job_id;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
